// File: rtl/logic_pod_pkg.sv
// rtl/logic_pod_pkg.sv - shared token type, format codes and flush states for the logic pod compressor
package logic_pod_pkg;

  localparam logic FMT_LITERAL = 1'b0;
  localparam logic FMT_RUN     = 1'b1;
  localparam int   TOKEN_W     = 17;

  typedef struct packed {
    logic        format;
    logic [15:0] data;
  } pod_token_t;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_CLOSE = 2'd1,
    FS_DRAIN = 2'd2,
    FS_DONE  = 2'd3
  } flush_state_e;

  function automatic pod_token_t make_token(input logic fmt, input logic [15:0] data);
    pod_token_t t;
    t.format = fmt;
    t.data   = data;
    return t;
  endfunction

endpackage

// File: rtl/logic_pod_token_queue.sv
// rtl/logic_pod_token_queue.sv - 2-write/1-read token FIFO with a registered head and sticky overflow
module logic_pod_token_queue
  import logic_pod_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en0,
  input  logic [TOKEN_W-1:0] wr_token0,
  input  logic               wr_en1,
  input  logic [TOKEN_W-1:0] wr_token1,
  output logic               out_valid,
  output logic [TOKEN_W-1:0] out_token,
  output logic               empty,
  output logic               overflow
);

  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  pod_token_t    mem [QDEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  pod_token_t    head_q;

  logic          pop_mem;
  logic [CW-1:0] base;
  logic [CW-1:0] free;
  logic          st0_en;
  logic          st1_en;
  pod_token_t    st0_tok;
  pod_token_t    st1_tok;
  logic          keep0;
  logic          keep1;

  // The output register always takes the oldest token; whatever is left is stored.
  always_comb begin
    pop_mem = (count != '0);
    base    = count - CW'(pop_mem);
    free    = CW'(QDEPTH) - base;
    if (pop_mem) begin
      st0_en  = wr_en0;
      st0_tok = wr_token0;
      st1_en  = wr_en1;
      st1_tok = wr_token1;
    end else begin
      st0_en  = wr_en1;
      st0_tok = wr_token1;
      st1_en  = 1'b0;
      st1_tok = wr_token1;
    end
    keep0 = st0_en && (free >= CW'(1));
    keep1 = st1_en && (free >= CW'(2));
  end

  always_ff @(posedge clk) begin
    if (keep0) mem[wr_ptr] <= st0_tok;
    if (keep1) mem[wr_ptr + 1'b1] <= st1_tok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      head_q    <= '0;
      overflow  <= 1'b0;
    end else begin
      if (pop_mem) begin
        out_valid <= 1'b1;
        head_q    <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1'b1;
      end else if (wr_en0) begin
        out_valid <= 1'b1;
        head_q    <= wr_token0;
      end else begin
        out_valid <= 1'b0;
      end
      wr_ptr <= wr_ptr + AW'(keep0) + AW'(keep1);
      count  <= base + CW'(keep0) + CW'(keep1);
      if ((st0_en && !keep0) || (st1_en && !keep1)) overflow <= 1'b1;
    end
  end

  assign out_token = head_q;
  assign empty     = (count == '0);

endmodule

// File: rtl/logic_pod_rle_compressor.sv
// rtl/logic_pod_rle_compressor.sv - logic pod sample compressor with flush sequencing
// Run-length encoding is built only when LOGIC_POD_RLE_EN is defined; otherwise every sample is a literal.
module logic_pod_rle_compressor
  import logic_pod_pkg::*;
#(
  parameter int               WIDTH   = 16,
  parameter int               QDEPTH  = 4,
  parameter logic [WIDTH-1:0] MAX_RUN = 16'hffff
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample_data,
  input  logic             flush,
  output logic             flush_busy,
  output logic             flush_done,
  output logic             compress_out_valid,
  output logic             compress_out_format,
  output logic [WIDTH-1:0] compress_out_data,
  output logic             overflow
);

  localparam logic [1:0] ST_IDLE  = FS_IDLE;
  localparam logic [1:0] ST_CLOSE = FS_CLOSE;
  localparam logic [1:0] ST_DRAIN = FS_DRAIN;
  localparam logic [1:0] ST_DONE  = FS_DONE;

  logic [1:0]  state;
  logic        accept;
  logic        sample_drop;
  logic        push0;
  logic        push1;
  pod_token_t  tok0;
  pod_token_t  tok1;
  logic [TOKEN_W-1:0] q_out;
  pod_token_t  q_head;
  logic        q_empty;
  logic        q_overflow;

  assign flush_busy = (state != ST_IDLE);
  assign flush_done = (state == ST_DONE);
  assign accept     = sample_valid && !flush_busy;

`ifdef LOGIC_POD_RLE_EN
  localparam logic [WIDTH-1:0] RUN_LAST = MAX_RUN - 1'b1;

  logic             have_prev;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] run_count;

  // A value change with a pending run emits the run first, then the new literal.
  always_comb begin
    push0 = 1'b0;
    push1 = 1'b0;
    tok0  = make_token(FMT_LITERAL, sample_data);
    tok1  = make_token(FMT_LITERAL, sample_data);
    if (state == ST_CLOSE) begin
      if (run_count != '0) begin
        push0 = 1'b1;
        tok0  = make_token(FMT_RUN, run_count);
      end
    end else if (accept) begin
      if (!have_prev || (sample_data != prev && run_count == '0)) begin
        push0 = 1'b1;
      end else if (sample_data == prev) begin
        if (run_count == RUN_LAST) begin
          push0 = 1'b1;
          tok0  = make_token(FMT_RUN, MAX_RUN);
        end
      end else begin
        push0 = 1'b1;
        tok0  = make_token(FMT_RUN, run_count);
        push1 = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      have_prev <= 1'b0;
      prev      <= '0;
      run_count <= '0;
    end else if (state == ST_CLOSE) begin
      have_prev <= 1'b0;
      run_count <= '0;
    end else if (accept) begin
      have_prev <= 1'b1;
      if (have_prev && sample_data == prev) begin
        run_count <= (run_count == RUN_LAST) ? '0 : run_count + 1'b1;
      end else begin
        prev      <= sample_data;
        run_count <= '0;
      end
    end
  end
`else
  always_comb begin
    push0 = accept;
    push1 = 1'b0;
    tok0  = make_token(FMT_LITERAL, sample_data);
    tok1  = make_token(FMT_LITERAL, sample_data);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      sample_drop <= 1'b0;
    end else begin
      if (sample_valid && flush_busy) sample_drop <= 1'b1;
      case (state)
        ST_IDLE:  if (flush) state <= ST_CLOSE;
        ST_CLOSE: state <= ST_DRAIN;
        ST_DRAIN: if (q_empty && !compress_out_valid) state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  logic_pod_token_queue #(
    .QDEPTH(QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .wr_en0    (push0),
    .wr_token0 (tok0),
    .wr_en1    (push1),
    .wr_token1 (tok1),
    .out_valid (compress_out_valid),
    .out_token (q_out),
    .empty     (q_empty),
    .overflow  (q_overflow)
  );

  assign q_head              = q_out;
  assign compress_out_format = q_head.format;
  assign compress_out_data   = q_head.data;
  assign overflow            = q_overflow || sample_drop;

endmodule
